// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: state width, state type and byte-order helpers.
// Byte 0 of a state occupies bits [127:120]; byte 15 occupies bits [7:0].
package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_NUM_BYTES = 16;

    typedef logic [AES_STATE_W-1:0] aes_state_t;

    function automatic logic [7:0] aes_get_byte(input aes_state_t s, input int unsigned idx);
        return s[AES_STATE_W-1-8*idx -: 8];
    endfunction

    function automatic aes_state_t aes_add_key(input aes_state_t s, input aes_state_t k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/add_round_key.sv
// AES AddRoundKey: combinational state^key plus a one-deep registered copy
// behind a valid/ready handshake that sustains one state per cycle.
module add_round_key
    import aes_pkg::*;
#(
    parameter int STATE_W = AES_STATE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] istate,
    input  logic [STATE_W-1:0] key,
    output logic [STATE_W-1:0] ostate,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    generate
        if (STATE_W != AES_STATE_W) begin : g_width_check
            $error("add_round_key: only STATE_W == 128 is supported");
        end
    endgenerate

    aes_state_t sum_s;
    logic       accept_s;
    logic       consume_s;
    logic       in_ready_s;
    aes_state_t out_data_r;
    logic       out_valid_r;

    // XOR result and handshake qualifiers
    always_comb begin
        sum_s      = aes_add_key(istate, key);
        in_ready_s = !out_valid_r || out_ready;
        accept_s   = in_valid && in_ready_s;
        consume_s  = out_valid_r && out_ready;
    end

    // Output slot: load on accept, empty on consume-only, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {AES_STATE_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sum_s;
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

    assign ostate    = sum_s;
    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key: directed checks plus a randomized
// scoreboard run against a byte-wise reference model.
module tb_add_round_key;

    logic         clk;
    logic         rst_n;
    logic [127:0] istate;
    logic [127:0] key;
    logic [127:0] ostate;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [127:0] exp_q[$];

    add_round_key dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .istate    (istate),
        .key       (key),
        .ostate    (ostate),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        #10;
        forever #5 clk = ~clk;
    end

    // Reference: AddRoundKey works byte by byte, byte 0 in the top bits
    function automatic logic [127:0] ref_ark(input logic [127:0] s, input logic [127:0] k);
        logic [127:0] r;
        logic [7:0]   sb;
        logic [7:0]   kb;
        r = 128'h0;
        for (int b = 0; b < 16; b++) begin
            sb = s[127-8*b -: 8];
            kb = k[127-8*b -: 8];
            r[127-8*b -: 8] = sb ^ kb;
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks handshake rules and pops the scoreboard on each consume
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready_rule", {127'h0, in_ready}, {127'h0, (!out_valid || out_ready)});
            chk("out_valid_vs_pending", {127'h0, out_valid}, {127'h0, (exp_q.size() != 0)});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", out_data, 128'hx);
                end else begin
                    chk("scoreboard_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    localparam logic [127:0] V1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1 = 128'h00102030405060708090a0b0c0d0e0f0;

    initial begin
        logic [127:0] held;
        logic [127:0] bp_s;
        logic [127:0] bp_k;
        logic [127:0] ps[4];
        logic [127:0] pk[4];
        bit acc;
        int accepted;
        int budget;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        istate    = V1;
        key       = K1;
        #5;
        chk("comb_vector", ostate, R1);
        rst_n = 1'b0;
        #2;
        chk("comb_vector_in_reset", ostate, R1);
        chk("reset_out_valid", {127'h0, out_valid}, 128'h0);
        chk("reset_out_data", out_data, 128'h0);
        chk("reset_in_ready", {127'h0, in_ready}, 128'h1);

        istate = rand128(); key = 128'h0; #1;
        chk("identity_key0", ostate, istate);
        istate = {16{8'hA5}}; key = {16{8'hA5}}; #1;
        chk("self_cancel", ostate, 128'h0);
        istate = 128'h0; key = {128{1'b1}}; #1;
        chk("invert_all_ones", ostate, {128{1'b1}});

        @(negedge clk);
        rst_n = 1'b1;
        istate = V1; key = K1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("reg_first_valid", {127'h0, out_valid}, 128'h1);
        chk("reg_first_data", out_data, R1);

        // Back-to-back: one result per cycle, in order
        for (int i = 0; i < 4; i++) begin
            ps[i] = rand128(); pk[i] = rand128();
        end
        for (int i = 0; i < 4; i++) begin
            istate = ps[i]; key = pk[i];
            tick();
            chk("b2b_valid", {127'h0, out_valid}, 128'h1);
            chk("b2b_data", out_data, ref_ark(ps[i], pk[i]));
        end

        // Back-pressure for three cycles with new data offered
        held = ref_ark(ps[3], pk[3]);
        bp_s = rand128(); bp_k = rand128();
        out_ready = 1'b0; istate = bp_s; key = bp_k; #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {127'h0, in_ready}, 128'h0);
            tick();
            chk("bp_out_valid", {127'h0, out_valid}, 128'h1);
            chk("bp_out_data_held", out_data, held);
        end
        out_ready = 1'b1; #1;
        chk("bp_release_in_ready", {127'h0, in_ready}, 128'h1);
        tick();
        chk("bp_release_data", out_data, ref_ark(bp_s, bp_k));

        // Reset pulse between edges drops the pending result at once
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {127'h0, out_valid}, 128'h0);
        chk("midreset_out_data", out_data, 128'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        istate = ps[0]; key = pk[1]; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("post_reset_data", out_data, ref_ark(ps[0], pk[1]));
        held = ref_ark(ps[0], pk[1]);
        in_valid = 1'b0; istate = rand128(); key = rand128();
        tick();
        chk("consume_only_valid", {127'h0, out_valid}, 128'h0);
        chk("consume_only_data_kept", out_data, held);

        // Randomized scoreboard run
        exp_q.delete();
        mon_en   = 1'b1;
        accepted = 0;
        for (int n = 0; n < 1000; n++) begin
            istate    = rand128();
            key       = rand128();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(ref_ark(istate, key));
                accepted++;
            end
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("drain_queue_empty", 128'(exp_q.size()), 128'h0);
        chk("drain_out_valid", {127'h0, out_valid}, 128'h0);
        chk("random_accepted_some", {127'h0, (accepted > 100)}, 128'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_round_key.md
Name: add_round_key

Overview:
AES AddRoundKey stage. It XORs a 128-bit AES state with a 128-bit round key. It provides a zero-latency combinational result and a one-deep registered result behind a valid/ready handshake. It sits between MixColumns (or the input block) and the next round in the AES datapath.

Parameters:
STATE_W, 128, state/key width in bits; only 128 is supported, and elaboration must fail for any other value.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
istate  input  128  input AES state; bits [127:120] are byte 0
key  input  128  round key, same byte order as istate
ostate  output  128  combinational result, istate XOR key
in_valid  input  1  istate/key are valid for the registered path
in_ready  output  1  stage can accept a new state/key this cycle
out_data  output  128  registered result
out_valid  output  1  out_data holds a result
out_ready  input  1  downstream consumes out_data this cycle

Behaviour:
- ostate = istate ^ key, bitwise over all 128 bits.
  - Purely combinational, zero latency.
  - Independent of clk, rst_n and the handshake; valid even while in reset.
- Reset (rst_n low, asynchronous assert, synchronous release on clk): out_valid=0, out_data=128'h0.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept: in_valid && in_ready at a rising clk edge.
  - out_data <= istate ^ key.
  - out_valid <= 1.
  - Latency is 1 cycle from accept to out_valid.
- Consume: out_valid && out_ready.
  - Consume without a simultaneous accept: out_valid <= 0; out_data keeps its last value.
  - Simultaneous consume and accept: out_valid stays 1; out_data is replaced by the new result. Full throughput is 1 state per cycle.
- Back-pressure (out_valid=1, out_ready=0): in_ready=0. out_data and out_valid hold stable until consumed.
- in_valid while in_ready=0: ignored. Upstream must hold its data.
- No accept: out_data is unchanged (no X or garbage loads).
- Reset asserted mid-operation: any pending result is dropped immediately (out_valid=0). No partial state survives.
- No byte reordering: bit i of the result depends only on bit i of istate and bit i of key.

Decomposition:
- Shared package aes_pkg:
  - AES_STATE_W=128
  - typedef aes_state_t (logic [127:0])
  - byte-index convention (byte 0 = MSBs)
- No sub-module. XOR and register stage live in add_round_key. aes_pkg is reused by SubBytes/ShiftRows/MixColumns.

Test Plan:
- Combinational check: istate=128'h00112233445566778899aabbccddeeff, key=128'h000102030405060708090a0b0c0d0e0f, with no clock edges, after 5 time units -> ostate=128'h00102030405060708090a0b0c0d0e0f0. Same values with rst_n=0 -> same ostate.
- Identity and inversion:
  - key=0 -> ostate=istate.
  - istate=key=128'hA5A5…A5 -> ostate=0.
  - istate=0, key=all-ones -> ostate=all-ones.
- Registered path: apply reset, then in_valid=1 with the vectors from the first scenario, out_ready=1 -> one cycle later out_valid=1 and out_data=128'h00102030405060708090a0b0c0d0e0f0. Back-to-back inputs each cycle -> one result per cycle, in order.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles while in_valid=1 with new data -> in_ready=0 and out_data unchanged. When out_ready goes to 1, the new result appears the next cycle.
- Reset mid-operation: out_valid=1 with out_data nonzero, then pulse rst_n low between clock edges -> out_valid=0 and out_data=0 immediately. After release, the first accepted input produces the correct result.
- Random: 1000 random istate/key pairs with random in_valid/out_ready -> every consumed out_data equals the istate^key of the matching accepted input, in order, with no drops or duplicates.
